bit_reverse_buffer: RTL and testbench
=====================================

BIT_REVERSE_BUFFER -- requirements
Module: bit_reverse_buffer

Interface
REQ-001 The block SHALL have parameter N, default 64: FFT frame length; a power of two, 4 to 4096.
REQ-002 The block SHALL have parameter WIDTH, default 16: bit length of each real/imag sample.
REQ-003 The block SHALL have port clock, input, 1 bit: master clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port di_en, input, 1 bit: input sample valid.
REQ-006 The block SHALL have port di_re / di_im, input, WIDTH bits each: input sample in bit-reversed order, as produced by the final SDF stage.
REQ-007 The block SHALL have port do_en, output, 1 bit: output sample valid.
REQ-008 The block SHALL have port do_re / do_im, output, WIDTH bits each: output sample in natural order.

Function
REQ-009 The block SHALL accept one sample on each clock edge where di_en=1; samples are numbered j=0..N-1 within a frame, and di_en may drop mid-frame.
REQ-010 The write counter SHALL advance only on accepted samples.
REQ-011 Accepted sample j SHALL be stored at address bitrev(j) (log2(N) bits) of the current write bank.
REQ-012 Storage SHALL be two banks (ping-pong) of N entries x 2*WIDTH bits.
REQ-013 When sample N-1 is accepted, the write bank SHALL be marked full, the write bank pointer SHALL toggle, and the write counter SHALL wrap to 0.
REQ-014 The read FSM SHALL have two states, IDLE and READ.
REQ-015 In IDLE, when a bank is full, the FSM SHALL go to READ and issue read address 0 of that bank.
REQ-016 In READ, the FSM SHALL issue addresses 0..N-1 linearly, one per clock, with no stalls.
REQ-017 After issuing address N-1, the FSM SHALL clear that bank's full flag, then start address 0 of the other bank on the next clock if that bank is full (back-to-back); otherwise it SHALL return to IDLE.
REQ-018 RAM read SHALL be synchronous and do_* SHALL be registered.
REQ-019 do_en=1 SHALL first appear with natural-order sample 0 exactly 2 clocks after the edge that accepted input sample N-1; with continuous input this gives a latency of N+1 clocks from first input to first output.
REQ-020 do_en SHALL stay high for exactly N consecutive clocks per frame.
REQ-021 With continuous input, do_en SHALL stay continuously high across frame boundaries.
REQ-022 Simultaneous write and read of different banks SHALL be supported.
REQ-023 Because N-cycle fill is never shorter than N-cycle drain, overrun is impossible and no overflow flag SHALL be provided.
REQ-024 The block SHALL NOT perform arithmetic; data SHALL pass bit-exact.
REQ-025 do_re / do_im SHALL hold undefined values while do_en=0 and SHALL be checked only while do_en=1.

Reset
REQ-026 Reset SHALL clear do_en to 0, the write counter to 0, the write bank pointer to bank 0, both full flags, and the FSM to IDLE, asynchronously.
REQ-027 RAM contents and do_re / do_im SHALL NOT be reset.
REQ-028 Reset mid-fill SHALL discard the partial frame; the next accepted sample after reset SHALL be j=0.
REQ-029 Reset mid-readout SHALL drop do_en immediately, and the remaining outputs of that frame SHALL be lost.

Structure
REQ-030 The shared FFT package/include SHALL hold the log2 helper and the bitrev(value, bits) function; both SHALL be reused by the SDF stages and the testbench.
REQ-031 The block SHALL use one sub-module, reorder_ram: simple dual-port, 2*N x 2*WIDTH bits, one write port, one synchronous read port, no reset.
REQ-032 Bank select SHALL be the MSB of the reorder_ram address.
REQ-033 The control logic (counters, full flags, FSM) SHALL remain in bit_reverse_buffer.

Verification
REQ-034 Scenario 1 (N=8): di_re=0..7 continuous, di_im=-di_re -> do_re = 0,4,2,6,1,5,3,7 and do_im negated; do_en high 8 clocks, rising 2 edges after the edge accepting sample 7.
REQ-035 Scenario 2 (N=64): single frame di_re=j -> output k has do_re=bitrev6(k) (k=1 gives 32, k=63 gives 63); exactly 64 do_en cycles.
REQ-036 Scenario 3 (N=64): 3 frames back-to-back, di_re = 64*f + j -> do_en high for 192 consecutive clocks; frame f output k = 64*f + bitrev6(k).
REQ-037 Scenario 4: di_en alternating 1/0 for one frame -> no do_en until 64 samples accepted, then 64 contiguous do_en cycles with correct order.
REQ-038 Scenario 5: reset after 20 accepted samples, then one full frame of 1000+j -> the only output is that frame, reordered; no stale data.
REQ-039 Scenario 6: reset asserted during output sample 10 -> do_en=0 immediately and no further output until a new full frame is accepted.

Source files
------------

// File: rtl/bit_reverse_buffer_pkg.sv
// Shared FFT helpers: log2 for power-of-two sizing and bit reversal of an index.
// Also holds the read-FSM state type used by the reorder buffer.
package bit_reverse_buffer_pkg;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    // Smallest r with 2**r >= value; exact log2 for powers of two.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Reverse the low 'bits' bits of value; upper bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int bits);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < bits) begin
                r = r | (((value >> i) & 32'd1) << (bits - 1 - i));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_reverse_buffer_reorder_ram.sv
// Simple dual-port reorder storage: one write port, one registered read port.
// Contents are never reset; the address MSB selects the ping-pong bank.
module reorder_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 32
) (
    input  logic          clock,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write port
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Synchronous read port
    always_ff @(posedge clock) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bit_reverse_buffer.sv
// Converts bit-reversed FFT output frames into natural order using a
// ping-pong pair of banks: writes scatter by bitrev(j), reads stream linearly.
module bit_reverse_buffer
    import bit_reverse_buffer_pkg::*;
#(
    parameter int N     = 64,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam int            AW   = log2(N);
    localparam int            DW   = 2 * WIDTH;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    // Write side
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic [31:0]   wr_rev_s;
    logic [AW:0]   wr_addr_s;
    logic          wr_last_s;
    logic [1:0]    full_q, full_d, full_set_s, full_clr_s;

    // Read side
    rd_state_e     state_q, state_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic          rd_bank_q, rd_bank_d;
    logic          rd_en_s;
    logic [AW:0]   rd_addr_s;
    logic [DW-1:0] rd_data_s;
    logic          rvalid_q;
    logic          do_en_q;
    logic [WIDTH-1:0] do_re_q, do_im_q;

    // Write counter, bank pointer and full-flag set requests
    always_comb begin
        wr_rev_s   = bitrev(32'(wr_cnt_q), AW);
        wr_addr_s  = {wr_bank_q, wr_rev_s[AW-1:0]};
        wr_last_s  = di_en && (wr_cnt_q == LAST);
        full_set_s = 2'b00;
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        if (di_en) begin
            if (wr_last_s) begin
                wr_cnt_d   = {AW{1'b0}};
                wr_bank_d  = ~wr_bank_q;
                full_set_s = wr_bank_q ? 2'b10 : 2'b01;
            end else begin
                wr_cnt_d   = wr_cnt_q + AW'(1);
                wr_bank_d  = wr_bank_q;
            end
        end else begin
            wr_cnt_d  = wr_cnt_q;
            wr_bank_d = wr_bank_q;
        end
    end

    // Read FSM: IDLE issues address 0 combinationally so a frame that
    // completes while finishing the previous one still streams gap-free.
    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_bank_d  = rd_bank_q;
        rd_en_s    = 1'b0;
        rd_addr_s  = {rd_bank_q, rd_cnt_q};
        full_clr_s = 2'b00;
        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_en_s   = 1'b1;
                    rd_addr_s = {rd_bank_q, {AW{1'b0}}};
                    rd_cnt_d  = AW'(1);
                    state_d   = RD_READ;
                end else begin
                    state_d   = RD_IDLE;
                end
            end
            RD_READ: begin
                rd_en_s   = 1'b1;
                rd_addr_s = {rd_bank_q, rd_cnt_q};
                if (rd_cnt_q == LAST) begin
                    full_clr_s = rd_bank_q ? 2'b10 : 2'b01;
                    rd_bank_d  = ~rd_bank_q;
                    rd_cnt_d   = {AW{1'b0}};
                    state_d    = full_q[~rd_bank_q] ? RD_READ : RD_IDLE;
                end else begin
                    rd_cnt_d   = rd_cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // A bank can only be set and cleared in the same cycle if it is the
    // write and read bank at once, which the ping-pong order never allows.
    always_comb begin
        full_d = (full_q & ~full_clr_s) | full_set_s;
    end

    // Control state with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_cnt_q  <= {AW{1'b0}};
            wr_bank_q <= 1'b0;
            full_q    <= 2'b00;
            state_q   <= RD_IDLE;
            rd_cnt_q  <= {AW{1'b0}};
            rd_bank_q <= 1'b0;
            rvalid_q  <= 1'b0;
            do_en_q   <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
            rvalid_q  <= rd_en_s;
            do_en_q   <= rvalid_q;
        end
    end

    // Output data register, intentionally not reset
    always_ff @(posedge clock) begin
        if (rvalid_q) begin
            do_re_q <= rd_data_s[DW-1:WIDTH];
            do_im_q <= rd_data_s[WIDTH-1:0];
        end
    end

    reorder_ram #(
        .DEPTH (2 * N),
        .AW    (AW + 1),
        .DW    (DW)
    ) u_ram (
        .clock   (clock),
        .we_i    (di_en),
        .waddr_i (wr_addr_s),
        .wdata_i ({di_re, di_im}),
        .re_i    (rd_en_s),
        .raddr_i (rd_addr_s),
        .rdata_o (rd_data_s)
    );

    assign do_en = do_en_q;
    assign do_re = do_re_q;
    assign do_im = do_im_q;

endmodule

// File: tb/tb_bit_reverse_buffer.sv
// Directed bench for bit_reverse_buffer: an N=8 table-driven frame plus
// N=64 sequences covering back-to-back frames, gapped input and resets.
module tb_bit_reverse_buffer;
    import bit_reverse_buffer_pkg::*;

    typedef struct {
        logic [15:0] di_re;
        logic [15:0] di_im;
        logic [15:0] exp_re;
        logic [15:0] exp_im;
    } vec_t;

    logic        clock;
    logic        rst8, en8, oen8;
    logic [15:0] re8, im8, ore8, oim8;
    logic        rst64, en64, oen64;
    logic [15:0] re64, im64, ore64, oim64;

    int n_vec;
    int n_err;

    // N=64 scoreboard state
    int          edge64, acc_j, full_edge, first_en, run, max_run, en_cnt;
    logic [15:0] frame_re [64];
    logic [15:0] frame_im [64];
    logic [15:0] out_re [64];
    logic [31:0] exp_q [$];

    vec_t tab [8];

    bit_reverse_buffer #(.N(8), .WIDTH(16)) dut8 (
        .clock (clock), .reset (rst8), .di_en (en8), .di_re (re8), .di_im (im8),
        .do_en (oen8), .do_re (ore8), .do_im (oim8)
    );

    bit_reverse_buffer #(.N(64), .WIDTH(16)) dut64 (
        .clock (clock), .reset (rst64), .di_en (en64), .di_re (re64), .di_im (im64),
        .do_en (oen64), .do_re (ore64), .do_im (oim64)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_stats();
        first_en = -1;
        run      = 0;
        max_run  = 0;
        en_cnt   = 0;
    endtask

    // One N=64 clock: drive, step past the edge, update model, check output.
    task automatic cyc64(input logic en, input logic [15:0] re, input logic [15:0] im);
        logic [31:0] tmp;
        en64 = en;
        re64 = re;
        im64 = im;
        @(posedge clock);
        #1;
        edge64++;
        if (en) begin
            frame_re[acc_j] = re;
            frame_im[acc_j] = im;
            if (acc_j == 63) begin
                for (int k = 0; k < 64; k++) begin
                    tmp = bitrev(32'(k), 6);
                    exp_q.push_back({frame_re[tmp[5:0]], frame_im[tmp[5:0]]});
                end
                full_edge = edge64;
            end
            acc_j = (acc_j + 1) % 64;
        end
        if (oen64 === 1'b1) begin
            if (first_en < 0) first_en = edge64;
            run++;
            if (run > max_run) max_run = run;
            if (en_cnt < 64) out_re[en_cnt] = ore64;
            en_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious do_en", 32'(oen64), 32'd0);
            end else begin
                chk("do data", {ore64, oim64}, exp_q.pop_front());
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic reset_now64(input string name);
        rst64 = 1'b1;
        #1;
        chk(name, 32'(oen64), 32'd0);
        acc_j = 0;
        exp_q.delete();
        @(negedge clock);
        rst64 = 1'b0;
    endtask

    task automatic idle64(input int n);
        for (int i = 0; i < n; i++) cyc64(1'b0, 16'd0, 16'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        edge64 = 0; acc_j = 0; full_edge = 0;
        clr_stats();
        rst8 = 1'b1; rst64 = 1'b1;
        en8 = 1'b0; re8 = 16'd0; im8 = 16'd0;
        en64 = 1'b0; re64 = 16'd0; im64 = 16'd0;

        tab[0] = '{16'd0, 16'h0000, 16'd0, 16'h0000};
        tab[1] = '{16'd1, 16'hFFFF, 16'd4, 16'hFFFC};
        tab[2] = '{16'd2, 16'hFFFE, 16'd2, 16'hFFFE};
        tab[3] = '{16'd3, 16'hFFFD, 16'd6, 16'hFFFA};
        tab[4] = '{16'd4, 16'hFFFC, 16'd1, 16'hFFFF};
        tab[5] = '{16'd5, 16'hFFFB, 16'd5, 16'hFFFB};
        tab[6] = '{16'd6, 16'hFFFA, 16'd3, 16'hFFFD};
        tab[7] = '{16'd7, 16'hFFF9, 16'd7, 16'hFFF9};

        repeat (3) @(posedge clock);
        #1;
        chk("reset do_en n8", 32'(oen8), 32'd0);
        chk("reset do_en n64", 32'(oen64), 32'd0);
        @(negedge clock);
        rst8 = 1'b0; rst64 = 1'b0;

        // N=8: sample j accepted on edge j, outputs on edges 9..16
        en8 = 1'b1; re8 = tab[0].di_re; im8 = tab[0].di_im;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            chk("n8 do_en", 32'(oen8), (c >= 9 && c <= 16) ? 32'd1 : 32'd0);
            if (c >= 9 && c <= 16) begin
                chk("n8 do_re", 32'(ore8), 32'(tab[c-9].exp_re));
                chk("n8 do_im", 32'(oim8), 32'(tab[c-9].exp_im));
            end
            if (c + 1 < 8) begin
                re8 = tab[c+1].di_re; im8 = tab[c+1].di_im;
            end else begin
                en8 = 1'b0;
            end
        end

        // Single N=64 frame
        clr_stats();
        for (int j = 0; j < 64; j++) cyc64(1'b1, 16'(j), ~16'(j));
        idle64(80);
        chk("s2 count", 32'(en_cnt), 32'd64);
        chk("s2 run", 32'(max_run), 32'd64);
        chk("s2 latency", 32'(first_en), 32'(full_edge + 2));
        chk("s2 k1", 32'(out_re[1]), 32'd32);
        chk("s2 k63", 32'(out_re[63]), 32'd63);
        chk("s2 drained", 32'(exp_q.size()), 32'd0);

        // Three frames back to back
        clr_stats();
        for (int i = 0; i < 192; i++) cyc64(1'b1, 16'(i), 16'(i + 7));
        idle64(80);
        chk("s3 count", 32'(en_cnt), 32'd192);
        chk("s3 run", 32'(max_run), 32'd192);

        // Alternating di_en
        clr_stats();
        for (int i = 0; i < 128; i++) cyc64((i % 2) == 0, 16'(300 + i / 2), 16'(i));
        idle64(80);
        chk("s4 count", 32'(en_cnt), 32'd64);
        chk("s4 run", 32'(max_run), 32'd64);
        chk("s4 latency", 32'(first_en), 32'(full_edge + 2));

        // Reset mid-fill discards the partial frame
        clr_stats();
        for (int j = 0; j < 20; j++) cyc64(1'b1, 16'(500 + j), 16'(j));
        reset_now64("s5 reset do_en");
        for (int j = 0; j < 64; j++) cyc64(1'b1, 16'(1000 + j), 16'(2000 + j));
        idle64(80);
        chk("s5 count", 32'(en_cnt), 32'd64);
        chk("s5 run", 32'(max_run), 32'd64);

        // Reset during output sample 10 kills the rest of the frame
        clr_stats();
        for (int j = 0; j < 64; j++) cyc64(1'b1, 16'(1200 + j), 16'(j));
        for (int i = 0; i < 40 && en_cnt < 11; i++) cyc64(1'b0, 16'd0, 16'd0);
        chk("s6 reached sample 10", 32'(en_cnt), 32'd11);
        reset_now64("s6 reset do_en");
        idle64(80);
        chk("s6 silent", 32'(en_cnt), 32'd11);
        clr_stats();
        for (int j = 0; j < 64; j++) cyc64(1'b1, 16'(3000 + j), 16'(j));
        idle64(80);
        chk("s6 new frame", 32'(en_cnt), 32'd64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
